load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Initiator side of the data-memory interface. Accepts one load/store request at a time from the core over a valid/ready handshake and drives the word-wide data memory through its address, write_data, MemRead and MemWrite signals. Performs byte, half and word accesses: sub-word stores use read-modify-write, and loads are sign- or zero-extended. Returns the result over a valid/ready response channel. Sits between the execute stage and the data memory.

Parameters:
MEM_LAT, 1, cycles MemRead is held before mem_read_data is sampled (>=1; 1 = combinational-read memory)
ADDR_W, 32, width of request and memory address buses
WORD_INDEXED, 1, 1: mem_address = req_addr >> 2 (memory indexed by word); 0: byte address passed through with [1:0] forced to 0

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  sign-extend a sub-word load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  load result, extended; 0 for stores
rsp_err  out  1  request was rejected, no memory write performed
mem_address  out  ADDR_W  to memory address
mem_write_data  out  32  to memory write_data
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe, sampled by memory on posedge

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=0 while rst_n=0. rsp_valid=0, rsp_rdata=0, rsp_err=0, MemRead=0, MemWrite=0, mem_address=0, mem_write_data=0. Asserting reset mid-operation drops MemWrite immediately and discards the request. No partial response is produced.
- FSM states: IDLE, READ, WRITE, RESP. All memory-side outputs are registered.
- IDLE: req_ready=1. On req_valid&&req_ready, latch size, signed, write, addr and wdata.
  - Reserved size goes to RESP with rsp_err=1.
  - Load, or store with size byte/half, goes to READ.
  - Word store goes to WRITE.
- READ: MemRead=1 and mem_address is driven for exactly MEM_LAT cycles (down-counter). mem_read_data is captured on the last cycle.
  - Load goes to RESP.
  - Sub-word store goes to WRITE.
- Lane rules are little-endian with off = addr[1:0]:
  - Byte load: lane off.
  - Half load: bits [16*addr[1]+:16].
  - Sign- or zero-extend per req_signed. Word load is returned unchanged.
  - Sub-word store: mem_write_data is the captured word with only the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0].
- WRITE: MemWrite=1 for exactly one cycle with mem_write_data valid, then RESP. MemRead=0 in WRITE. MemRead and MemWrite are never high together.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE. rsp_ready high on entry still costs one RESP cycle.
- Latency from accept to rsp_valid:
  - Load: MEM_LAT+1 cycles.
  - Word store: 2 cycles.
  - Sub-word store: MEM_LAT+2 cycles.
  - Error: 1 cycle.
- Back-to-back: req_ready is low outside IDLE, so the earliest next accept is the cycle after the response handshake.
- Misalignment handling (no macro): low address bits below access size are ignored. Half uses addr[1], word ignores addr[1:0].
- WORD_INDEXED=1: address wrap beyond memory depth is the memory's concern; the unit passes the index unchanged.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE->RESP with rsp_err=1 and rsp_rdata=0. No MemRead or MemWrite is issued.
- Undefined: misaligned bits are ignored as described above, and rsp_err is raised only for reserved size.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - State enum.
  - Function lane_extract(word, off, size, signed).
  - Function lane_merge(word, off, size, wdata).
- Sub-module lsu_lane_align (combinational extract/merge) is natural and reused by the bench's reference model. FSM and counter stay in the top.

Test Plan:
- Word load, MEM_LAT=1, memory word 3=0x0000001B, req_addr=0x0C: MemRead high exactly 1 cycle with mem_address=3; rsp_valid 2 cycles after accept; rsp_rdata=0x0000001B, rsp_err=0.
- Signed byte load: word 1=0x000080FF, addr=0x05, signed=1 -> rsp_rdata=0xFFFFFF80. Same with signed=0 -> 0x00000080.
- Half store RMW: word 4=0x000003FF, addr=0x12, wdata=0xABCD: one MemRead, then one MemWrite with mem_write_data=0xABCD03FF. Never both strobes high together.
- Response backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no memory strobes. Next req_valid accepted the cycle after the handshake.
- Reset during WRITE: rst_n low mid-cycle -> MemWrite drops asynchronously, no response. After release, req_ready=1 and all outputs 0.
- Size=11 -> rsp_err=1 one cycle after accept, no strobes. With MISALIGN_TRAP_EN, word load at addr=0x06 -> rsp_err=1, no MemRead.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: size/state encodings and little-endian lane helpers for load_store_unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input size_e size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        return size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
               size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] off,
                                               input size_e size, input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE)
            r[{off, 3'b000} +: 8] = wdata[7:0];
        else if (size == SZ_HALF)
            r[{off[1], 4'b0000} +: 16] = wdata[15:0];
        else
            r = wdata;
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational load extraction and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    assign rdata  = lane_extract(word, off, size, sgn);
    assign merged = lane_merge(word, off, size, wdata);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator with sub-word RMW and load extension.
// Optional MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of ignoring low bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int ADDR_W       = 32,
    parameter int WORD_INDEXED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic              MemRead,
    output logic              MemWrite
);

    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;

    state_e            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              wr, wr_n, sgn, sgn_n;
    size_e             size, size_n;
    logic [1:0]        off, off_n;
    logic [31:0]       wdata, wdata_n;
    logic              mem_read_n, mem_write_n, rsp_valid_n, rsp_err_n;
    logic [ADDR_W-1:0] mem_address_n, idx;
    logic [31:0]       mem_write_data_n, rsp_rdata_n, ext, merged;
    logic              mis;

    lsu_lane_align u_align (
        .word   (mem_read_data),
        .off    (off),
        .size   (size),
        .sgn    (sgn),
        .wdata  (wdata),
        .rdata  (ext),
        .merged (merged)
    );

    assign req_ready = rst_n && state == IDLE;
    assign idx = (WORD_INDEXED != 0) ? (req_addr >> 2) : {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign mis = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        wr_n             = wr;
        sgn_n            = sgn;
        size_n           = size;
        off_n            = off;
        wdata_n          = wdata;
        mem_read_n       = 1'b0;
        mem_write_n      = 1'b0;
        mem_address_n    = mem_address;
        mem_write_data_n = mem_write_data;
        rsp_valid_n      = rsp_valid;
        rsp_err_n        = rsp_err;
        rsp_rdata_n      = rsp_rdata;
        case (state)
            IDLE: if (req_valid) begin
                wr_n    = req_write;
                sgn_n   = req_signed;
                size_n  = size_e'(req_size);
                off_n   = req_addr[1:0];
                wdata_n = req_wdata;
                if (req_size == SZ_RSVD || mis) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                end else if (req_write && req_size == SZ_WORD) begin
                    state_n          = WRITE;
                    mem_write_n      = 1'b1;
                    mem_address_n    = idx;
                    mem_write_data_n = req_wdata;
                end else begin
                    state_n       = READ;
                    mem_read_n    = 1'b1;
                    mem_address_n = idx;
                    cnt_n         = CW'(MEM_LAT - 1);
                end
            end
            READ: if (cnt != '0) begin
                mem_read_n = 1'b1;
                cnt_n      = cnt - 1'b1;
            end else if (wr) begin
                state_n          = WRITE;
                mem_write_n      = 1'b1;
                mem_write_data_n = merged;
            end else begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_rdata_n = ext;
            end
            WRITE: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_rdata_n = '0;
            end
            RESP: if (rsp_ready) begin
                state_n     = IDLE;
                rsp_valid_n = 1'b0;
                rsp_err_n   = 1'b0;
                rsp_rdata_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            wr             <= 1'b0;
            sgn            <= 1'b0;
            size           <= SZ_BYTE;
            off            <= 2'b00;
            wdata          <= '0;
            MemRead        <= 1'b0;
            MemWrite       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            wr             <= wr_n;
            sgn            <= sgn_n;
            size           <= size_n;
            off            <= off_n;
            wdata          <= wdata_n;
            MemRead        <= mem_read_n;
            MemWrite       <= mem_write_n;
            mem_address    <= mem_address_n;
            mem_write_data <= mem_write_data_n;
            rsp_valid      <= rsp_valid_n;
            rsp_err        <= rsp_err_n;
            rsp_rdata      <= rsp_rdata_n;
        end
    end

endmodule
